// File: rtl/axis_skid_reg_if.sv
// AXI4-Stream channel bundle (data, valid, ready) shared by producer and consumer.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_skid_reg.sv
// Two-entry AXI4-Stream skid buffer: fully registered pipeline stage with a
// synchronous flush, sustaining one beat per cycle.
module axis_skid_reg (
  input  logic   clk,
  input  logic   rst_n,
  axis_if.slave  axis_sif,
  axis_if.master axis_mif,
  input  logic   invalidate
);
  localparam int W = $bits(axis_sif.tdata);

  logic         r_main_vld_p1;
  logic         r_skid_vld_p1;
  logic [W-1:0] r_main_data_p1;
  logic [W-1:0] r_skid_data_p1;

  logic w_in_hs;
  logic w_out_hs;
  logic w_main_vld_nxt;
  logic w_skid_vld_nxt;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_skid_from_in;

  // ready depends only on the skid flag, so no input reaches an output combinationally
  assign w_in_hs  = axis_sif.tvalid && !r_skid_vld_p1;
  assign w_out_hs = r_main_vld_p1 && axis_mif.tready;

  // ---- stage p1: occupancy flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else begin
      r_main_vld_p1 <= w_main_vld_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
    end
  end

  always_comb begin
    w_main_vld_nxt   = r_main_vld_p1;
    w_skid_vld_nxt   = r_skid_vld_p1;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    if (invalidate) begin
      w_main_vld_nxt = 1'b0;
      w_skid_vld_nxt = 1'b0;
    end else if (r_skid_vld_p1) begin
      if (w_out_hs) begin
        w_main_from_skid = 1'b1;
        w_skid_vld_nxt   = 1'b0;
      end
    end else if (!r_main_vld_p1) begin
      if (w_in_hs) begin
        w_main_from_in = 1'b1;
        w_main_vld_nxt = 1'b1;
      end
    end else begin
      if (w_in_hs && w_out_hs) begin
        w_main_from_in = 1'b1;
      end else if (w_in_hs) begin
        w_skid_from_in = 1'b1;
        w_skid_vld_nxt = 1'b1;
      end else if (w_out_hs) begin
        w_main_vld_nxt = 1'b0;
      end
    end
  end

  // ---- stage p1: data registers (no reset, qualified by the flags) ----
  always_ff @(posedge clk) begin
    if (w_main_from_in) begin
      r_main_data_p1 <= axis_sif.tdata;
    end else if (w_main_from_skid) begin
      r_main_data_p1 <= r_skid_data_p1;
    end
    if (w_skid_from_in) begin
      r_skid_data_p1 <= axis_sif.tdata;
    end
  end

  always_comb begin
    axis_mif.tvalid = r_main_vld_p1;
    axis_mif.tdata  = r_main_data_p1;
    axis_sif.tready = !r_skid_vld_p1;
  end
endmodule

// File: tb/tb_axis_skid_reg.sv
// Randomized and directed scoreboard bench for axis_skid_reg.
module tb_axis_skid_reg;
  logic clk = 1'b0;
  logic rst_n;
  logic invalidate;

  axis_if #(.TDATA_WIDTH(8)) sif ();
  axis_if #(.TDATA_WIDTH(8)) mif ();

  axis_skid_reg dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .axis_sif   (sif.slave),
    .axis_mif   (mif.master),
    .invalidate (invalidate)
  );

  always #5 clk = ~clk;

  // Reference: the block is an ordered store of at most two accepted beats.
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       last_in_hs;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares DUT outputs against the reference store every cycle.
  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (!rst_n) begin
      check("reset_tvalid", mif.tvalid, 1'b0);
      check("reset_tready", sif.tready, 1'b1);
      prev_stall = 1'b0;
    end else begin
      check("tvalid", mif.tvalid, exp_q.size() > 0);
      check("tready", sif.tready, exp_q.size() < 2);
      if (prev_stall) check("stall_stable", mif.tdata, prev_data);
      if (mif.tvalid && mif.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", mif.tdata, 32'hFFFF_FFFF);
        end else begin
          exp_d = exp_q.pop_front();
          check("out_data", mif.tdata, exp_d);
        end
      end
      prev_stall = mif.tvalid && !mif.tready && !invalidate;
      prev_data  = mif.tdata;
    end
  end

  // One clock of stimulus; inputs are already set just after the previous edge.
  task automatic step(input logic inv);
    logic hs;
    invalidate = inv;
    @(negedge clk);
    #1;
    hs = 1'b0;
    if (rst_n) begin
      hs = sif.tvalid && sif.tready;
      if (inv) exp_q.delete();
      else if (hs) exp_q.push_back(sif.tdata);
    end
    last_in_hs = hs;
    @(posedge clk);
    #1;
    invalidate = 1'b0;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", mif.tvalid, 1'b0);
    check("async_rst_tready", sif.tready, 1'b1);
    exp_q.delete();
    sif.tvalid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic       pending;
    logic [7:0] beats[3];
    rst_n      = 1'b0;
    invalidate = 1'b0;
    sif.tvalid = 1'b0;
    sif.tdata  = '0;
    mif.tready = 1'b0;
    #1;
    check("por_tvalid", mif.tvalid, 1'b0);
    check("por_tready", sif.tready, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) step(1'b0);

    // streaming
    beats = '{8'h11, 8'h22, 8'h33};
    mif.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sif.tvalid = 1'b1;
      sif.tdata  = beats[i];
      step(1'b0);
      check("stream_latency", mif.tdata, beats[i]);
      check("stream_tready", sif.tready, 1'b1);
    end
    sif.tvalid = 1'b0;
    repeat (3) step(1'b0);

    // stall: A and B accepted, C held upstream
    mif.tready = 1'b0;
    sif.tvalid = 1'b1;
    sif.tdata  = 8'h0A;
    step(1'b0);
    sif.tdata = 8'h0B;
    step(1'b0);
    check("stall_tready_low", sif.tready, 1'b0);
    sif.tdata = 8'h0C;
    repeat (3) begin
      step(1'b0);
      check("stall_head", mif.tdata, 8'h0A);
    end
    mif.tready = 1'b1;
    begin
      int budget = 10;
      last_in_hs = 1'b0;
      while (!last_in_hs && budget > 0) begin
        step(1'b0);
        budget--;
      end
      check("stall_c_accepted", last_in_hs, 1'b1);
    end
    sif.tvalid = 1'b0;
    repeat (4) step(1'b0);

    // flush while FULL
    mif.tready = 1'b0;
    sif.tvalid = 1'b1;
    sif.tdata  = 8'h71;
    step(1'b0);
    sif.tdata = 8'h72;
    step(1'b0);
    sif.tvalid = 1'b0;
    step(1'b1);
    check("flush_tvalid", mif.tvalid, 1'b0);
    check("flush_tready", sif.tready, 1'b1);
    mif.tready = 1'b1;
    repeat (3) step(1'b0);

    // flush with concurrent input
    sif.tvalid = 1'b1;
    sif.tdata  = 8'h55;
    step(1'b1);
    sif.tvalid = 1'b0;
    check("flush_drop_tvalid", mif.tvalid, 1'b0);
    repeat (3) step(1'b0);

    // randomized traffic with occasional flushes and one mid-stream reset
    pending = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!pending) begin
        sif.tvalid = ($urandom_range(0, 3) != 0);
        sif.tdata  = 8'($urandom);
        pending    = sif.tvalid;
      end
      mif.tready = (c < 5000) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) != 0);
      if (c == 6000) begin
        mid_reset();
        pending = 1'b0;
      end else begin
        step($urandom_range(0, 63) == 0);
        if (last_in_hs) pending = 1'b0;
      end
    end
    sif.tvalid = 1'b0;
    mif.tready = 1'b1;
    repeat (4) step(1'b0);
    check("drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
